// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, unsigned Bitwidth-bit dividend / divisor -> quotient, remainder.
// Latency: start to done is Bitwidth+1 cycles (1 cycle for a zero divisor); one result per Bitwidth+2 cycles.
// Backpressure: none; start is only accepted in IDLE and is ignored (not queued) while busy.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   start              request, accepted only in IDLE; dividend/divisor sampled on the accepting edge
//   dividend, divisor  unsigned operands, Bitwidth bits
//   quotient,          registered results, updated only on entry to DONE (or cleared by rst),
//   remainder,         held stable until the next DONE
//   div_by_zero        registered flag qualifying the held result
//   busy               high whenever the FSM is not in IDLE
//   done               one-cycle pulse while in DONE, results valid
module seq_divider #(
    parameter int Bitwidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [Bitwidth-1:0] dividend,
    input  logic [Bitwidth-1:0] divisor,
    output logic [Bitwidth-1:0] quotient,
    output logic [Bitwidth-1:0] remainder,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero
);

    localparam int CW = $clog2(Bitwidth) + 1;  // cnt must hold the value Bitwidth
    localparam int AW = 2 * Bitwidth + 1;      // acc = {partial remainder (W+1), quotient/dividend (W)}

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [AW-1:0]       acc;
    logic [Bitwidth-1:0] dreg;
    logic [CW-1:0]       cnt;

    // FSM control strobes
    logic load;       // accept a request with a nonzero divisor
    logic load_zero;  // accept a request with a zero divisor
    logic step;       // perform one restoring iteration
    logic finish;     // this iteration is the last one

    // One restoring iteration on acc
    logic [Bitwidth:0]   upper_sh;    // upper part after the left shift
    logic [Bitwidth+1:0] diff;        // trial subtraction, MSB is the borrow
    logic                fits;
    logic [Bitwidth:0]   upper_next;
    logic [Bitwidth-1:0] lower_next;
    logic [AW-1:0]       acc_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_zero  = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // Zero divisor skips RUN; the result is written on entry to DONE.
                        load_zero  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring step. The shifted-out top bit of acc is always zero
    // (partial remainder < divisor), but it is kept in the subtraction so
    // the compare is exact on the full shifted value.
    // ------------------------------------------------------------------
    always_comb begin
        upper_sh   = acc[AW-2:Bitwidth-1];
        diff       = {acc[AW-1], upper_sh} - {2'b00, dreg};
        fits       = ~diff[Bitwidth+1];
        upper_next = fits ? diff[Bitwidth:0] : upper_sh;
        lower_next = {acc[Bitwidth-2:0], fits};
        acc_next   = {upper_next, lower_next};
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            dreg        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                dreg <= divisor;
                acc  <= {{(Bitwidth + 1){1'b0}}, dividend};
                cnt  <= CW'(Bitwidth);
            end

            if (load_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end

            if (step) begin
                acc <= acc_next;
                cnt <= cnt - CW'(1);
                // Results are captured from the final iteration so they are
                // already valid in the DONE cycle and never move otherwise.
                if (finish) begin
                    quotient    <= lower_next;
                    remainder   <= upper_next[Bitwidth-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider at Bitwidth 8 and 16.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        start8;
    logic [7:0]  dd8, dv8, q8, r8;
    logic        busy8, done8, dz8;

    logic        start16;
    logic [15:0] dd16, dv16, q16, r16;
    logic        busy16, done16, dz16;

    int ntest = 0;
    int nfail = 0;

    // Result the 8-bit unit is expected to be holding between done pulses.
    logic [7:0] pq8, pr8;
    logic       pz8;

    seq_divider #(.Bitwidth(8)) u8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dd8),
        .divisor     (dv8),
        .quotient    (q8),
        .remainder   (r8),
        .busy        (busy8),
        .done        (done8),
        .div_by_zero (dz8)
    );

    seq_divider #(.Bitwidth(16)) u16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .dividend    (dd16),
        .divisor     (dv16),
        .quotient    (q16),
        .remainder   (r16),
        .busy        (busy16),
        .done        (done16),
        .div_by_zero (dz16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Reference: plain arithmetic; a zero divisor gives all ones / dividend / flag.
    function automatic void ref8(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r, output logic z);
        if (b == 8'd0) begin
            q = 8'hFF; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Issue one request in the current (IDLE) cycle and follow it to done.
    // With hold=1, start stays high carrying ha/hb for the whole operation.
    task automatic div8(input logic [7:0] a, input logic [7:0] b,
                        input bit hold, input logic [7:0] ha, input logic [7:0] hb);
        int         lat;
        int         exp_lat;
        logic [7:0] eq, er;
        logic       ez;
        ref8(a, b, eq, er, ez);
        exp_lat = (b == 8'd0) ? 1 : 9;

        start8 = 1'b1; dd8 = a; dv8 = b;
        sample();
        chk("idle_busy", busy8, 0);
        next_cycle();
        lat = 0;
        while (1) begin
            lat++;
            start8 = hold;
            dd8    = hold ? ha : 8'($urandom);
            dv8    = hold ? hb : 8'($urandom);
            sample();
            chk("busy", busy8, 1);
            if (done8) break;
            chk("held_result", {q8, r8, dz8}, {pq8, pr8, pz8});
            if (lat >= 40) begin
                ntest++;
                nfail++;
                $error("FAIL timeout8: no done after %0d cycles, expected at %0d", lat, exp_lat);
                return;
            end
            next_cycle();
        end
        chk("latency", lat, exp_lat);
        chk("quotient", q8, eq);
        chk("remainder", r8, er);
        chk("div_by_zero", dz8, ez);
        pq8 = eq; pr8 = er; pz8 = ez;
        if (!hold) start8 = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] a16, b16;
        logic [7:0]  ra, rb;

        rst = 1'b1;
        start8 = 1'b0; dd8 = '0; dv8 = '0;
        start16 = 1'b0; dd16 = '0; dv16 = '0;
        pq8 = '0; pr8 = '0; pz8 = 1'b0;

        next_cycle();
        next_cycle();
        rst = 1'b0;
        sample();
        chk("rst_quotient", q8, 0);
        chk("rst_remainder", r8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_dbz", dz8, 0);
        chk("rst_busy16", busy16, 0);
        next_cycle();

        // Basic division, then back-to-back requests in the first IDLE cycle.
        div8(8'd200, 8'd7, 1'b0, 8'd0, 8'd0);
        next_cycle();
        div8(8'd255, 8'd1, 1'b0, 8'd0, 8'd0);
        next_cycle();
        div8(8'd0, 8'd5, 1'b0, 8'd0, 8'd0);
        next_cycle();

        // Zero divisor, then a normal division clears the flag.
        div8(8'd13, 8'd0, 1'b0, 8'd0, 8'd0);
        next_cycle();
        div8(8'd9, 8'd3, 1'b0, 8'd0, 8'd0);
        next_cycle();

        // start held high during the operation is ignored, then accepted in IDLE.
        div8(8'd100, 8'd9, 1'b1, 8'd50, 8'd5);
        next_cycle();
        div8(8'd50, 8'd5, 1'b0, 8'd0, 8'd0);
        next_cycle();

        // Reset in cycle 4 of a running division.
        start8 = 1'b1; dd8 = 8'd100; dv8 = 8'd9;
        next_cycle();
        start8 = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        sample();
        chk("rst_mid_done", done8, 0);
        next_cycle();
        rst = 1'b0;
        sample();
        chk("rst_mid_busy", busy8, 0);
        chk("rst_mid_outputs", {q8, r8, dz8, done8}, 0);
        pq8 = '0; pr8 = '0; pz8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            sample();
            chk("rst_mid_quiet", {busy8, done8}, 0);
        end
        next_cycle();
        div8(8'd100, 8'd9, 1'b0, 8'd0, 8'd0);
        next_cycle();

        // Random 8-bit operands, zero divisors included now and then.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            div8(ra, rb, 1'b0, 8'd0, 8'd0);
            next_cycle();
        end

        // 16-bit random pairs with nonzero divisor; check the division identity.
        for (int i = 0; i < 2000; i++) begin
            case (i)
                0: begin a16 = 16'hFFFF; b16 = 16'd1;    end
                1: begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
                2: begin a16 = 16'hFFFE; b16 = 16'hFFFF; end
                3: begin a16 = 16'd0;    b16 = 16'd3;    end
                default: begin
                    a16 = 16'($urandom);
                    b16 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15))
                                                      : 16'($urandom_range(1, 65535));
                end
            endcase
            start16 = 1'b1; dd16 = a16; dv16 = b16;
            next_cycle();
            start16 = 1'b0; dd16 = 16'($urandom); dv16 = 16'($urandom);
            lat = 0;
            while (1) begin
                sample();
                if (done16) break;
                lat++;
                if (lat > 40) begin
                    ntest++;
                    nfail++;
                    $error("FAIL timeout16: no done after %0d cycles, expected within 17", lat);
                    break;
                end
                next_cycle();
            end
            chk("identity16", 32'(q16) * 32'(b16) + 32'(r16), 32'(a16));
            chk("rem_lt_div16", 32'(r16 < b16), 1);
            chk("quotient16", q16, a16 / b16);
            chk("dbz16", dz16, 0);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
